// File: rtl/phase3_pkg.sv
// Shared direction codes, default combination table and sequencer state encoding
// for the Phase 3 direction-combination path.
package phase3_pkg;

  localparam int DIR_W = 3;

  localparam logic [DIR_W-1:0] DIR_N  = 3'd0;
  localparam logic [DIR_W-1:0] DIR_E  = 3'd1;
  localparam logic [DIR_W-1:0] DIR_W_ = 3'd2;
  localparam logic [DIR_W-1:0] DIR_S  = 3'd3;

  localparam int unsigned DEFAULT_LEN = 5;

  // Element 0 sits in the least significant slot: N, S, E, W, N.
  localparam logic [DEFAULT_LEN-1:0][DIR_W-1:0] DEFAULT_SEQ =
    {DIR_N, DIR_W_, DIR_E, DIR_S, DIR_N};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE,
    ST_ABORTED
  } seq_state_t;

  // Default table entry for slot i; slots past the built-in sequence reset to north.
  function automatic logic [DIR_W-1:0] default_dir(input int unsigned i);
    if (i < DEFAULT_LEN) return DEFAULT_SEQ[i[2:0]];
    return '0;
  endfunction

endpackage

// File: rtl/phase3_gap_timer.sv
// Loadable down-counter that times the idle gap between direction steps.
// With GAP_CYCLES==0 no counter is built and the zero flag is constant high.
module phase3_gap_timer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  generate
    if (GAP_CYCLES == 0) begin : g_none
      logic w_unused;
      assign w_unused = ^{clk, reset, i_load, i_dec};
      assign o_zero   = 1'b1;
    end else begin : g_cnt
      localparam int CNT_W = $clog2(GAP_CYCLES + 1);
      logic [CNT_W-1:0] r_cnt;

      // Loaded with GAP_CYCLES-1 so the final gap cycle is the one that sees zero.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (i_load) begin
          r_cnt <= CNT_W'(GAP_CYCLES - 1);
        end else if (i_dec && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      assign o_zero = (r_cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/phase3_dir_sequencer.sv
// Plays a programmable table of direction codes, one per valid/ready handshake, into the Phase 3 checker.
// Optional macro DIR_PARITY_EN adds a registered odd-parity output alongside dir_out.
module phase3_dir_sequencer #(
  parameter int SEQ_LEN    = 5,
  parameter int DIR_W      = 3,
  parameter int GAP_CYCLES = 0,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [DIR_W-1:0] cfg_dir,
  output logic [DIR_W-1:0] dir_out,
  output logic             dir_valid,
  input  logic             dir_ready,
  output logic             busy,
  output logic             seq_done,
  output logic             seq_aborted
`ifdef DIR_PARITY_EN
  ,
  output logic             dir_parity
`endif
);
  import phase3_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  seq_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DIR_W-1:0] r_table [SEQ_LEN];
  logic [DIR_W-1:0] r_dir_out;
  logic             r_dir_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic             w_idle_like;
  logic             w_go;
  logic             w_hs;
  logic             w_last;
  logic             w_adv;
  logic             w_cfg_wr;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [DIR_W-1:0] w_tbl0;
  logic [DIR_W-1:0] w_dir_new;
  logic             w_dir_load;
  logic             w_gap_zero;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ABORTED);
  assign w_go        = w_idle_like && start && !abort;
  assign w_hs        = (r_state == ST_SEND) && r_dir_valid && dir_ready && !abort;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_adv       = w_hs && !w_last;
  assign w_cfg_wr    = cfg_we && !r_busy && (int'(cfg_addr) < SEQ_LEN);
  assign w_nxt_idx   = w_last ? r_idx : r_idx + IDX_W'(1);

  // A table write landing with start must be visible in the first presented code.
  assign w_tbl0      = (w_cfg_wr && (cfg_addr == '0)) ? cfg_dir : r_table[0];
  assign w_dir_new   = w_go ? w_tbl0 : r_table[w_nxt_idx];
  assign w_dir_load  = w_go || w_adv;

  phase3_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_adv),
    .i_dec  (r_state == ST_GAP),
    .o_zero (w_gap_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_dir_out   <= '0;
      r_dir_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      for (int i = 0; i < SEQ_LEN; i++) r_table[i] <= DIR_W'(default_dir(i));
    end else begin
      if (w_cfg_wr) r_table[cfg_addr] <= cfg_dir;
      if (w_dir_load) r_dir_out <= w_dir_new;

      case (r_state)
        ST_SEND, ST_GAP: begin
          // Abort wins over a handshake in the same cycle; that step is dropped.
          if (abort) begin
            r_state     <= ST_ABORTED;
            r_dir_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_aborted   <= 1'b1;
          end else if (r_state == ST_GAP) begin
            if (w_gap_zero) begin
              r_state     <= ST_SEND;
              r_dir_valid <= 1'b1;
            end
          end else if (w_hs) begin
            if (w_last) begin
              r_state     <= ST_DONE;
              r_dir_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_idx <= w_nxt_idx;
              if (GAP_CYCLES != 0) begin
                r_state     <= ST_GAP;
                r_dir_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          if (w_go) begin
            r_state     <= ST_SEND;
            r_idx       <= '0;
            r_dir_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dir_out     = r_dir_out;
  assign dir_valid   = r_dir_valid;
  assign busy        = r_busy;
  assign seq_done    = r_done;
  assign seq_aborted = r_aborted;

`ifdef DIR_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_parity <= 1'b1;
    end else if (w_dir_load) begin
      r_parity <= ~^w_dir_new;
    end
  end

  assign dir_parity = r_parity;
`endif

endmodule

// File: tb/tb_phase3_dir_sequencer.sv
// Self-checking bench for phase3_dir_sequencer: a no-gap instance and a GAP_CYCLES=2 instance share stimulus.
module tb_phase3_dir_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [2:0] cfg_dir;
  logic       dir_ready;

  logic [2:0] a_dir_out;
  logic       a_dir_valid, a_busy, a_done, a_aborted;
  logic [2:0] g_dir_out;
  logic       g_dir_valid, g_busy, g_done, g_aborted;
`ifdef DIR_PARITY_EN
  logic       a_parity, g_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  phase3_dir_sequencer #(.SEQ_LEN(5), .DIR_W(3), .GAP_CYCLES(0), .IDX_W(3)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dir(cfg_dir),
    .dir_out(a_dir_out), .dir_valid(a_dir_valid), .dir_ready(dir_ready),
    .busy(a_busy), .seq_done(a_done), .seq_aborted(a_aborted)
`ifdef DIR_PARITY_EN
    , .dir_parity(a_parity)
`endif
  );

  phase3_dir_sequencer #(.SEQ_LEN(5), .DIR_W(3), .GAP_CYCLES(2), .IDX_W(3)) u_gap (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dir(cfg_dir),
    .dir_out(g_dir_out), .dir_valid(g_dir_valid), .dir_ready(dir_ready),
    .busy(g_busy), .seq_done(g_done), .seq_aborted(g_aborted)
`ifdef DIR_PARITY_EN
    , .dir_parity(g_parity)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [2:0] d0, d1, d2, d3, d4);
    exp_q = {};
    exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2);
    exp_q.push_back(d3); exp_q.push_back(d4);
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((a_busy || g_busy) && n < 60) begin tick; n++; end
    n_checks++;
    if (a_busy || g_busy) begin
      n_fail++; $display("FAIL wait_idle: busy a=%0d g=%0d after %0d cycles, required 0", a_busy, g_busy, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; tick;
    n_checks++; if (a_dir_out !== 3'd0) begin n_fail++; $display("FAIL rst_dir_out: got %0d required 0", a_dir_out); end
    n_checks++; if (a_dir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dir_valid: got %0d required 0", a_dir_valid); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0d required 0", a_busy); end
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0d required 0", a_done); end
    n_checks++; if (a_aborted !== 1'b0) begin n_fail++; $display("FAIL rst_aborted: got %0d required 0", a_aborted); end
    n_checks++; if (g_dir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_gap_valid: got %0d required 0", g_dir_valid); end
`ifdef DIR_PARITY_EN
    n_checks++; if (a_parity !== 1'b1) begin n_fail++; $display("FAIL rst_parity: got %0d required 1", a_parity); end
`endif
    reset = 1'b1; tick;
  endtask

  task automatic test_default_seq;
    logic [2:0] e;
    wait_idle;
    push_seq(3'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    dir_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_checks++; if (a_dir_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid c%0d: got %0d required 1", c, a_dir_valid); end
      n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy c%0d: got %0d required 1", c, a_busy); end
      e = exp_q.pop_front();
      n_checks++; if (a_dir_out !== e) begin n_fail++; $display("FAIL seq_dir c%0d: got %0d required %0d", c, a_dir_out, e); end
      tick;
    end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL seq_done: got %0d required 1", a_done); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy_end: got %0d required 0", a_busy); end
    n_checks++; if (a_dir_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_end: got %0d required 0", a_dir_valid); end
  endtask

  task automatic test_stall;
    logic [2:0] e;
    int hs = 0, stall = 0, cyc = 0;
    wait_idle;
    push_seq(3'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    dir_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    while (hs < 5 && cyc < 40) begin
      cyc++;
      n_checks++; if (a_dir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc%0d: got %0d required 1", cyc, a_dir_valid); end
      if (hs == 1 && stall < 4) begin
        n_checks++; if (a_dir_out !== 3'd3) begin n_fail++; $display("FAIL stall_hold cyc%0d: got %0d required 3", cyc, a_dir_out); end
        dir_ready = 1'b0; stall++;
      end else begin
        dir_ready = 1'b1; e = exp_q.pop_front(); hs++;
        n_checks++; if (a_dir_out !== e) begin n_fail++; $display("FAIL stall_dir hs%0d: got %0d required %0d", hs, a_dir_out, e); end
      end
      tick;
    end
    dir_ready = 1'b1;
    n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL stall_cycles: got %0d required 9", cyc); end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %0d required 1", a_done); end
  endtask

  task automatic test_gap;
    logic [2:0] e;
    logic       ev;
    int hs = 0;
    wait_idle;
    push_seq(3'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    dir_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      ev = ((c - 1) % 3 == 0);
      n_checks++; if (g_dir_valid !== ev) begin n_fail++; $display("FAIL gap_valid c%0d: got %0d required %0d", c, g_dir_valid, ev); end
      if (g_dir_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front(); hs++;
        n_checks++; if (g_dir_out !== e) begin n_fail++; $display("FAIL gap_dir hs%0d: got %0d required %0d", hs, g_dir_out, e); end
      end
      tick;
    end
    n_checks++; if (hs != 5) begin n_fail++; $display("FAIL gap_handshakes: got %0d required 5", hs); end
    n_checks++; if (g_done !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %0d required 1", g_done); end
  endtask

  task automatic test_abort;
    logic [2:0] e;
    wait_idle;
    push_seq(3'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    dir_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      e = exp_q.pop_front();
      n_checks++; if (a_dir_out !== e) begin n_fail++; $display("FAIL abort_pre c%0d: got %0d required %0d", c, a_dir_out, e); end
      tick;
    end
    n_checks++; if (a_dir_out !== 3'd1) begin n_fail++; $display("FAIL abort_step3: got %0d required 1", a_dir_out); end
    abort = 1'b1; tick; abort = 1'b0;
    n_checks++; if (a_dir_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %0d required 0", a_dir_valid); end
    n_checks++; if (a_aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %0d required 1", a_aborted); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d required 0", a_busy); end
    n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0d required 0", a_done); end
    abort = 1'b1; start = 1'b1; tick; abort = 1'b0; start = 1'b0;
    n_checks++; if (a_dir_valid !== 1'b0) begin n_fail++; $display("FAIL abort_start_ignored: valid got %0d required 0", a_dir_valid); end
    n_checks++; if (a_aborted !== 1'b1) begin n_fail++; $display("FAIL abort_hold: got %0d required 1", a_aborted); end
    push_seq(3'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    start = 1'b1; tick; start = 1'b0;
    n_checks++; if (a_aborted !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got %0d required 0", a_aborted); end
    for (int c = 1; c <= 5; c++) begin
      e = exp_q.pop_front();
      n_checks++; if (a_dir_valid !== 1'b1 || a_dir_out !== e) begin n_fail++; $display("FAIL restart_dir c%0d: got v%0d d%0d required v1 d%0d", c, a_dir_valid, a_dir_out, e); end
      tick;
    end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %0d required 1", a_done); end
  endtask

  task automatic test_cfg_write;
    logic [2:0] e;
    logic [2:0] wr_dat [5];
    wr_dat = '{3'd2, 3'd2, 3'd1, 3'd0, 3'd3};
    wait_idle;
    cfg_we = 1'b1;
    for (int a = 1; a <= 4; a++) begin cfg_addr = 3'(a); cfg_dir = wr_dat[a]; tick; end
    cfg_addr = 3'd5; cfg_dir = 3'd7; tick;
    cfg_addr = 3'd0; cfg_dir = wr_dat[0]; start = 1'b1; tick;
    cfg_we = 1'b0; start = 1'b0;
    push_seq(3'd2, 3'd2, 3'd1, 3'd0, 3'd3);
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin cfg_we = 1'b1; cfg_addr = 3'd3; cfg_dir = 3'd7; end
      else cfg_we = 1'b0;
      e = exp_q.pop_front();
      n_checks++; if (a_dir_valid !== 1'b1 || a_dir_out !== e) begin n_fail++; $display("FAIL cfg_dir c%0d: got v%0d d%0d required v1 d%0d", c, a_dir_valid, a_dir_out, e); end
      tick;
    end
    cfg_we = 1'b0;
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL cfg_done: got %0d required 1", a_done); end
  endtask

  task automatic test_reset_mid;
    logic [2:0] e;
    wait_idle;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      n_checks++; if (a_dir_out !== 3'd2) begin n_fail++; $display("FAIL mid_pre c%0d: got %0d required 2", c, a_dir_out); end
      tick;
    end
    reset = 1'b0; tick;
    n_checks++; if ({a_dir_out, a_dir_valid, a_busy, a_done, a_aborted} !== 7'd0)
      begin n_fail++; $display("FAIL mid_reset_outputs: got %0h required 0", {a_dir_out, a_dir_valid, a_busy, a_done, a_aborted}); end
    reset = 1'b1;
    push_seq(3'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      e = exp_q.pop_front();
      n_checks++; if (a_dir_valid !== 1'b1 || a_dir_out !== e) begin n_fail++; $display("FAIL mid_reload c%0d: got v%0d d%0d required v1 d%0d", c, a_dir_valid, a_dir_out, e); end
      tick;
    end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %0d required 1", a_done); end
  endtask

`ifdef DIR_PARITY_EN
  task automatic test_parity;
    logic [2:0] e;
    wait_idle;
    push_seq(3'd0, 3'd3, 3'd1, 3'd2, 3'd0);
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      e = exp_q.pop_front();
      n_checks++; if (a_parity !== ~^e) begin n_fail++; $display("FAIL parity c%0d: got %0d required %0d", c, a_parity, ~^e); end
      tick;
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_addr = 3'd0; cfg_dir = 3'd0; dir_ready = 1'b1;
    tick; tick;
    test_reset;
    test_default_seq;
    test_stall;
    test_gap;
    test_abort;
    test_cfg_write;
    test_reset_mid;
`ifdef DIR_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase3_dir_sequencer.md
Name: phase3_dir_sequencer

Overview:
- Transmit side of the Phase 3 direction-combination interface.
- Holds a programmable table of SEQ_LEN 3-bit direction codes and plays them out, one per valid/ready handshake, to the Phase 3 checker's direction input.
- Used by the auto-dial/test path to drive the vault's direction-sequence checker.
- Supports an inter-step gap, abort, and done/aborted status.

Parameters:
- SEQ_LEN, 5, number of directions played per sequence (≥1).
- DIR_W, 3, direction code width.
- GAP_CYCLES, 0, idle cycles between a handshake and presentation of the next direction.
- IDX_W, 3, table index width (≥ clog2(SEQ_LEN)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low
- start  in  1  begin playback (sampled in IDLE/DONE/ABORTED)
- abort  in  1  cancel playback
- cfg_we  in  1  table write strobe
- cfg_addr  in  IDX_W  table write index
- cfg_dir  in  DIR_W  table write data
- dir_out  out  DIR_W  current direction code
- dir_valid  out  1  dir_out valid
- dir_ready  in  1  sink accepts dir_out
- busy  out  1  high in SEND/GAP
- seq_done  out  1  level, high in DONE
- seq_aborted  out  1  level, high in ABORTED

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, idx=0.
  - dir_out=0, dir_valid=0, busy=0, seq_done=0, seq_aborted=0.
  - Table reloaded with package defaults 0,3,1,2,0.
- All outputs are registered.
- States: IDLE, SEND, GAP, DONE, ABORTED.
- IDLE/DONE/ABORTED + start=1, abort=0 → SEND at the next edge:
  - idx=0, dir_out=table[0], dir_valid=1, busy=1.
  - seq_done and seq_aborted cleared.
  - Latency: start at cycle t gives dir_valid at t+1.
- SEND:
  - dir_out is held stable while dir_valid=1 and dir_ready=0.
  - Handshake = dir_valid & dir_ready at a clock edge.
  - Handshake with idx==SEQ_LEN-1 → DONE: dir_valid=0, busy=0, seq_done=1 from the next cycle.
  - Handshake otherwise, GAP_CYCLES==0 → stay SEND: idx+1, dir_out=table[idx+1], dir_valid stays 1 (back-to-back).
  - Handshake otherwise, GAP_CYCLES>0 → GAP: dir_valid=0, gap counter loaded.
  - GAP lasts exactly GAP_CYCLES cycles. Handshake at h gives the next dir_valid=1 at h+1+GAP_CYCLES.
- abort=1 in SEND/GAP → ABORTED at the next edge: dir_valid=0, busy=0, seq_aborted=1.
  - Abort beats a simultaneous handshake; that handshake is not counted.
- abort=1 in IDLE/DONE/ABORTED: no state change, and any simultaneous start is ignored.
- start while busy is ignored.
- Table writes:
  - cfg_we=1 writes table[cfg_addr]=cfg_dir at the edge, only when busy=0.
  - Ignored while busy.
  - Ignored when cfg_addr ≥ SEQ_LEN.
  - A write in the same cycle as start takes effect; playback reads table[0] after the write.
- reset mid-playback: immediate return to IDLE defaults; the partial sequence is discarded.
- idx never exceeds SEQ_LEN-1. There is no wrap; each sequence is one-shot.

Optional Feature:
- Macro: DIR_PARITY_EN.
- Defined:
  - Adds output dir_parity (1 bit), registered alongside dir_out, equal to odd parity of dir_out (XOR of bits inverted).
  - dir_parity=1 on reset, which is odd parity of 0.
- Undefined: port absent, no parity logic.

Decomposition:
- Package phase3_pkg holds:
  - DIR_W.
  - Direction codes DIR_N=0, DIR_E=1, DIR_W_=2, DIR_S=3.
  - DEFAULT_SEQ constant array (0,3,1,2,0).
  - Sequencer state enum.
- One natural sub-module, phase3_gap_timer: loadable down-counter with load, zero flag, and generate-out when GAP_CYCLES==0.

Test Plan:
- Default table, dir_ready tied 1, GAP=0, start at t → dir_out 0,3,1,2,0 on t+1..t+5, dir_valid high t+1..t+5, seq_done=1 at t+6, busy 0.
- dir_ready low for 4 cycles on step 2 → dir_out held at 3 with dir_valid=1 throughout; sequence completes 4 cycles later with correct order.
- GAP_CYCLES=2, ready=1 → dir_valid pattern 1,0,0,1,0,0,… with 5 handshakes; seq_done after the 5th handshake.
- abort asserted in the same cycle as the 3rd handshake → ABORTED next cycle, dir_valid=0, seq_aborted=1; a new start restarts at table[0] and clears seq_aborted.
- Write table to 2,2,1,0,3 while idle; write attempted while busy is ignored; playback emits 2,2,1,0,3. Reset (reset=0) mid-sequence → all outputs 0, table back to 0,3,1,2,0.
- DIR_PARITY_EN defined: dir_out=3 → dir_parity=1; dir_out=1 → dir_parity=0.
